// File: rtl/sar_ctrl.sv
// ---------------------------------------------------------------------------
// sar_ctrl -- successive-approximation ADC controller (8-bit result).
//
// A conversion tracks the input for SAMPLE_CYCLES clocks, then resolves the
// result MSB first. Each bit trial drives dac_code = working | trial_bit and
// keeps (cmp_in=1) or drops (cmp_in=0) that bit. No adders on the data path:
// the trial bit is a one-hot mask shifted right once per bit.
//
// Optional build macro: SAR_SETTLE_EN
//   defined   : each bit trial is followed by SETTLE_CYCLES clocks of SETTLE
//               with dac_code held; cmp_in is taken on the last SETTLE edge.
//   undefined : SETTLE state and its counter do not exist; one clock per bit.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset (wins over ena and start)
//   ena        in   clock enable; low freezes every register and output
//   start      in   conversion request, accepted in IDLE or DONE only
//   cmp_in     in   comparator, 1 = Vin >= Vdac(dac_code)
//   sample     out  track-and-hold control, 1 = track
//   dac_code   out  [7:0] DAC code under trial
//   busy       out  high through SAMPLE and all bit trials
//   done       out  one-clock pulse when result updates
//   result     out  [7:0] last completed conversion
//   fsm_state  out  [2:0] current state (IDLE=0 SAMPLE=1 TRIAL=2 SETTLE=3
//                   DONE=4), debug visibility only
// ---------------------------------------------------------------------------
module sar_ctrl #(
    parameter int SAMPLE_CYCLES = 2,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       start,
    input  logic       cmp_in,
    output logic       sample,
    output logic [7:0] dac_code,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic [2:0] fsm_state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SAMPLE = 3'd1,
        TRIAL  = 3'd2,
`ifdef SAR_SETTLE_EN
        SETTLE = 3'd3,
`endif
        DONE   = 3'd4
    } state_t;

    // Both counts must fit the 4-bit counters; reject bad overrides early.
    if (SAMPLE_CYCLES < 1 || SAMPLE_CYCLES > 15) begin : g_bad_sample
        $error("sar_ctrl: SAMPLE_CYCLES out of range 1..15");
    end
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("sar_ctrl: SETTLE_CYCLES out of range 1..15");
    end

    localparam logic [3:0] SAMPLE_LOAD = 4'(SAMPLE_CYCLES);
`ifdef SAR_SETTLE_EN
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);
    logic [3:0] settle_cnt;
`endif

    state_t     state;
    logic [3:0] samp_cnt;
    logic [7:0] working;
    logic [7:0] mask;       // one-hot bit under trial, 0 outside trials
    logic [7:0] bit_word;   // working with the trial bit resolved by cmp_in

    assign bit_word  = cmp_in ? (working | mask) : (working & ~mask);
    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            samp_cnt <= 4'd0;
            working  <= 8'h00;
            mask     <= 8'h00;
            sample   <= 1'b0;
            dac_code <= 8'h00;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= 8'h00;
`ifdef SAR_SETTLE_EN
            settle_cnt <= 4'd0;
`endif
        end else if (ena) begin
            case (state)
                IDLE, DONE: begin
                    done     <= 1'b0;
                    dac_code <= 8'h00;
                    mask     <= 8'h00;
                    if (start) begin
                        // A start in DONE goes straight back to SAMPLE.
                        state    <= SAMPLE;
                        samp_cnt <= SAMPLE_LOAD;
                        working  <= 8'h00;
                        sample   <= 1'b1;
                        busy     <= 1'b1;
                    end else begin
                        state  <= IDLE;
                        sample <= 1'b0;
                        busy   <= 1'b0;
                    end
                end

                SAMPLE: begin
                    if (samp_cnt == 4'd1) begin
                        state    <= TRIAL;
                        samp_cnt <= 4'd0;
                        sample   <= 1'b0;
                        mask     <= 8'h80;
                        dac_code <= 8'h80;
                    end else begin
                        samp_cnt <= samp_cnt - 4'd1;
                    end
                end

`ifdef SAR_SETTLE_EN
                TRIAL: begin
                    state      <= SETTLE;
                    settle_cnt <= SETTLE_LOAD;
                end

                SETTLE: begin
                    if (settle_cnt == 4'd1) begin
                        settle_cnt <= 4'd0;
                        working    <= bit_word;
                        if (mask[0]) begin
                            state    <= DONE;
                            result   <= bit_word;
                            done     <= 1'b1;
                            busy     <= 1'b0;
                            mask     <= 8'h00;
                            dac_code <= 8'h00;
                        end else begin
                            state    <= TRIAL;
                            mask     <= mask >> 1;
                            dac_code <= bit_word | (mask >> 1);
                        end
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
`else
                TRIAL: begin
                    working <= bit_word;
                    if (mask[0]) begin
                        state    <= DONE;
                        result   <= bit_word;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        mask     <= 8'h00;
                        dac_code <= 8'h00;
                    end else begin
                        mask     <= mask >> 1;
                        dac_code <= bit_word | (mask >> 1);
                    end
                end
`endif

                default: begin
                    state    <= IDLE;
                    sample   <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                    mask     <= 8'h00;
                    dac_code <= 8'h00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sar_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sar_ctrl -- directed self-checking bench for sar_ctrl.
// The analog side is modelled as cmp_in = (vin >= dac_code). Expected codes,
// results and latencies are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_sar_ctrl;

`ifdef SAR_SETTLE_EN
    localparam int PER_BIT = 3;
`else
    localparam int PER_BIT = 1;
`endif
    localparam int LAT = 2 + 8 * PER_BIT;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       start = 1'b0;
    logic       cmp_in;
    logic       sample;
    logic [7:0] dac_code;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic [2:0] fsm_state;

    logic [7:0] vin = 8'h00;
    logic [7:0] trace [64];
    logic [7:0] exp_seq [8];
    int         tcnt;
    int         lat;
    int         n_vec = 0;
    int         n_fail = 0;

    assign cmp_in = (vin >= dac_code);

    always #5 clk = ~clk;

    sar_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .start     (start),
        .cmp_in    (cmp_in),
        .sample    (sample),
        .dac_code  (dac_code),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .fsm_state (fsm_state)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Start one conversion and record every bit-trial dac_code until done.
    // lat = edges from the accepting edge to the edge that raised done.
    task automatic run_conv(input logic [7:0] v);
        vin   = v;
        start = 1'b1;
        tick();
        start = 1'b0;
        tcnt  = 0;
        lat   = -1;
        for (int i = 1; i <= 80; i++) begin
            tick();
            if (busy && !sample && tcnt < 64) begin
                trace[tcnt] = dac_code;
                tcnt++;
            end
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b1;
        tick();
        tick();
        n_vec++; if (sample !== 1'b0) begin n_fail++; $display("FAIL reset_sample got %b want 0", sample); end
        n_vec++; if (dac_code !== 8'h00) begin n_fail++; $display("FAIL reset_dac got %h want 00", dac_code); end
        n_vec++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_vec++; if (result !== 8'h00) begin n_fail++; $display("FAIL reset_result got %h want 00", result); end
        n_vec++; if (fsm_state !== 3'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", fsm_state); end
        // First edge out of reset accepts the start that was already high.
        rst_n = 1'b1;
        tick();
        start = 1'b0;
        n_vec++; if (sample !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL first_start got sample=%b busy=%b want 1 1", sample, busy); end
        for (int i = 0; i < 80 && !done; i++) tick();
        tick();
    endtask

    task automatic test_convert_a5;
        exp_seq[0] = 8'h80; exp_seq[1] = 8'hC0; exp_seq[2] = 8'hA0; exp_seq[3] = 8'hB0;
        exp_seq[4] = 8'hA8; exp_seq[5] = 8'hA4; exp_seq[6] = 8'hA6; exp_seq[7] = 8'hA5;
        run_conv(8'hA5);
        n_vec++; if (lat !== LAT) begin n_fail++; $display("FAIL a5_latency got %0d want %0d", lat, LAT); end
        n_vec++; if (result !== 8'hA5) begin n_fail++; $display("FAIL a5_result got %h want a5", result); end
        n_vec++; if (tcnt !== 8 * PER_BIT) begin n_fail++; $display("FAIL a5_trial_clocks got %0d want %0d", tcnt, 8 * PER_BIT); end
        for (int k = 0; k < 8; k++) begin
            n_vec++;
            if (trace[k * PER_BIT] !== exp_seq[k]) begin
                n_fail++; $display("FAIL a5_dac[%0d] got %h want %h", k, trace[k * PER_BIT], exp_seq[k]);
            end
        end
        n_vec++; if (busy !== 1'b0 || dac_code !== 8'h00) begin n_fail++; $display("FAIL a5_done_outputs got busy=%b dac=%h want 0 00", busy, dac_code); end
        tick();
        n_vec++; if (done !== 1'b0) begin n_fail++; $display("FAIL a5_done_pulse got %b want 0", done); end
        n_vec++; if (result !== 8'hA5) begin n_fail++; $display("FAIL a5_result_hold got %h want a5", result); end
    endtask

    task automatic test_extremes;
        run_conv(8'h00);
        n_vec++; if (result !== 8'h00) begin n_fail++; $display("FAIL zero_result got %h want 00", result); end
        n_vec++; if (trace[7 * PER_BIT] !== 8'h01) begin n_fail++; $display("FAIL zero_last_dac got %h want 01", trace[7 * PER_BIT]); end
        tick();
        run_conv(8'hFF);
        n_vec++; if (result !== 8'hFF) begin n_fail++; $display("FAIL full_result got %h want ff", result); end
        n_vec++; if (trace[8 * PER_BIT - 1] !== 8'hFF) begin n_fail++; $display("FAIL full_last_dac got %h want ff", trace[8 * PER_BIT - 1]); end
        tick();
    endtask

    task automatic test_start_ignored;
        int dones;
        int first;
        dones = 0;
        first = -1;
        vin   = 8'hA5;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2 + 3 * PER_BIT; i++) tick();
        n_vec++; if (dac_code !== 8'hB0) begin n_fail++; $display("FAIL ign_bit4_dac got %h want b0", dac_code); end
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 4 + 3 * PER_BIT; e <= 60; e++) begin
            if (done) begin
                dones++;
                if (first < 0) first = e - 1;
            end
            tick();
        end
        n_vec++; if (dones !== 1) begin n_fail++; $display("FAIL ign_done_count got %0d want 1", dones); end
        n_vec++; if (first !== LAT) begin n_fail++; $display("FAIL ign_latency got %0d want %0d", first, LAT); end
    endtask

    task automatic test_back_to_back;
        vin   = 8'hA5;
        start = 1'b1;
        tick();
        lat = -1;
        for (int i = 1; i <= 80; i++) begin
            tick();
            if (done) begin lat = i; break; end
        end
        n_vec++; if (lat !== LAT) begin n_fail++; $display("FAIL b2b_first_latency got %0d want %0d", lat, LAT); end
        tick();
        start = 1'b0;
        n_vec++; if (sample !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL b2b_sample_rise got sample=%b busy=%b want 1 1", sample, busy); end
        lat = -1;
        for (int i = 1; i <= 80; i++) begin
            tick();
            if (done) begin lat = i; break; end
        end
        n_vec++; if (lat !== LAT) begin n_fail++; $display("FAIL b2b_second_latency got %0d want %0d", lat, LAT); end
        n_vec++; if (result !== 8'hA5) begin n_fail++; $display("FAIL b2b_result got %h want a5", result); end
        tick();
    endtask

    task automatic test_ena_freeze;
        int edges;
        vin   = 8'hA5;
        start = 1'b1;
        tick();
        start = 1'b0;
        edges = 0;
        for (int i = 0; i < 2 + 4 * PER_BIT; i++) begin tick(); edges++; end
        n_vec++; if (dac_code !== 8'hA8) begin n_fail++; $display("FAIL ena_bit3_dac got %h want a8", dac_code); end
        ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); edges++;
            n_vec++; if (dac_code !== 8'hA8 || busy !== 1'b1) begin n_fail++; $display("FAIL ena_frozen got dac=%h busy=%b want a8 1", dac_code, busy); end
        end
        ena = 1'b1;
        lat = -1;
        for (int i = 0; i < 80; i++) begin
            tick(); edges++;
            if (done) begin lat = edges; break; end
        end
        n_vec++; if (lat !== LAT + 3) begin n_fail++; $display("FAIL ena_latency got %0d want %0d", lat, LAT + 3); end
        n_vec++; if (result !== 8'hA5) begin n_fail++; $display("FAIL ena_result got %h want a5", result); end
        ena = 1'b0;
        tick();
        tick();
        n_vec++; if (done !== 1'b1) begin n_fail++; $display("FAIL ena_done_held got %b want 1", done); end
        ena = 1'b1;
        tick();
        n_vec++; if (done !== 1'b0) begin n_fail++; $display("FAIL ena_done_release got %b want 0", done); end
    endtask

    task automatic test_reset_mid;
        int dones;
        dones = 0;
        vin   = 8'hA5;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2 + 2 * PER_BIT; i++) tick();
        n_vec++; if (dac_code !== 8'hA0) begin n_fail++; $display("FAIL rst_bit5_dac got %h want a0", dac_code); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_vec++; if (sample !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ctrl got sample=%b busy=%b done=%b want 0 0 0", sample, busy, done); end
        n_vec++; if (dac_code !== 8'h00) begin n_fail++; $display("FAIL rst_mid_dac got %h want 00", dac_code); end
        n_vec++; if (result !== 8'h00) begin n_fail++; $display("FAIL rst_mid_result got %h want 00", result); end
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) dones++;
        end
        n_vec++; if (dones !== 0) begin n_fail++; $display("FAIL rst_mid_no_done got %0d want 0", dones); end
    endtask

`ifdef SAR_SETTLE_EN
    task automatic test_settle;
        int bad;
        bad = 0;
        run_conv(8'h3C);
        n_vec++; if (lat !== 26) begin n_fail++; $display("FAIL settle_latency got %0d want 26", lat); end
        n_vec++; if (result !== 8'h3C) begin n_fail++; $display("FAIL settle_result got %h want 3c", result); end
        for (int k = 0; k < 8; k++) begin
            if (trace[3 * k] !== trace[3 * k + 1] || trace[3 * k] !== trace[3 * k + 2]) bad++;
        end
        n_vec++; if (bad !== 0) begin n_fail++; $display("FAIL settle_hold got %0d unheld bits want 0", bad); end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_convert_a5();
        test_extremes();
        test_start_ignored();
        test_back_to_back();
        test_ena_freeze();
        test_reset_mid();
`ifdef SAR_SETTLE_EN
        test_settle();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    // Hard stop so a stuck DUT can never hang the run.
    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish, miscompares=%0d", n_fail);
        $fatal(1, "timeout");
    end

endmodule
